// File: rtl/rst_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | rst_seq_ctrl : staged CORE -> TX -> RX reset release with software restart|
// | and optional watchdog (compiled in by RST_SEQ_WDOG_EN).   Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module rst_seq_ctrl #(
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4,
   parameter int CNT_W       = 8,
   parameter int WDOG_CYCLES = 1000,
   parameter int WDOG_W      = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SW_RST_REQ,
   input  logic       WDOG_KICK,
   output logic       RST_CORE_N,
   output logic       RST_TX_N,
   output logic       RST_RX_N,
   output logic       DONE,
   output logic [1:0] STATE,
   output logic       WDOG_FLAG
);

   typedef enum logic [1:0] {
      S_HOLD = 2'd0,
      S_GAP1 = 2'd1,
      S_GAP2 = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             core_n_q, core_n_d;
   logic             tx_n_q, tx_n_d;
   logic             rx_n_q, rx_n_d;
   logic             done_q, done_d;
   logic             wdog_expire;
   logic             restart;

   assign restart = SW_RST_REQ | wdog_expire;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      core_n_d = core_n_q;
      tx_n_d   = tx_n_q;
      rx_n_d   = rx_n_q;
      done_d   = done_q;
      if (restart) begin
         state_d  = S_HOLD;
         cnt_d    = '0;
         core_n_d = 1'b0;
         tx_n_d   = 1'b0;
         rx_n_d   = 1'b0;
         done_d   = 1'b0;
      end else begin
         case (state_q)
            S_HOLD: begin
               if (cnt_q == C_HOLD_LAST) begin
                  state_d  = S_GAP1;
                  cnt_d    = '0;
                  core_n_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_GAP1: begin
               if (cnt_q == C_GAP_LAST) begin
                  state_d = S_GAP2;
                  cnt_d   = '0;
                  tx_n_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_GAP2: begin
               if (cnt_q == C_GAP_LAST) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  rx_n_d  = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               // RUN is terminal; the counter parks at zero so it can never wrap
               cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= S_HOLD;
         cnt_q    <= '0;
         core_n_q <= 1'b0;
         tx_n_q   <= 1'b0;
         rx_n_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         core_n_q <= core_n_d;
         tx_n_q   <= tx_n_d;
         rx_n_q   <= rx_n_d;
         done_q   <= done_d;
      end
   end

`ifdef RST_SEQ_WDOG_EN
   localparam logic [WDOG_W-1:0] C_WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

   logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
   logic              wdog_flag_q, wdog_flag_d;

   assign wdog_expire = (state_q == S_RUN) && !WDOG_KICK && (wdog_cnt_q == C_WDOG_LAST);

   always_comb begin
      wdog_cnt_d  = wdog_cnt_q + 1'b1;
      wdog_flag_d = wdog_flag_q;
      if ((state_q != S_RUN) || WDOG_KICK || restart) begin
         wdog_cnt_d = '0;
      end
      // A software request on the expiry edge owns the restart, so no flag
      if (wdog_expire && !SW_RST_REQ) begin
         wdog_flag_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wdog_cnt_q  <= '0;
         wdog_flag_q <= 1'b0;
      end else begin
         wdog_cnt_q  <= wdog_cnt_d;
         wdog_flag_q <= wdog_flag_d;
      end
   end

   assign WDOG_FLAG = wdog_flag_q;
`else
   logic unused_wdog;

   assign unused_wdog = WDOG_KICK ^ (WDOG_CYCLES > 0) ^ (WDOG_W > 0);
   assign wdog_expire = 1'b0;
   assign WDOG_FLAG   = 1'b0;
`endif

   assign RST_CORE_N = core_n_q;
   assign RST_TX_N   = tx_n_q;
   assign RST_RX_N   = rx_n_q;
   assign DONE       = done_q;
   assign STATE      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_rst_seq_ctrl : directed checks of reset release timing, restarts,     |
// | async reset and watchdog (behaviour follows RST_SEQ_WDOG_EN).  Rev 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rst_seq_ctrl;

   localparam int C_HOLD = 16;
   localparam int C_GAP  = 4;
   localparam int C_WDOG = 10;
   localparam int C_RUN  = C_HOLD + 2 * C_GAP;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       SW_RST_REQ = 1'b0;
   logic       WDOG_KICK = 1'b0;
   logic       RST_CORE_N, RST_TX_N, RST_RX_N, DONE, WDOG_FLAG;
   logic [1:0] STATE;

   int n_vec = 0;
   int n_err = 0;
   bit exp_flag = 1'b0;

   rst_seq_ctrl #(
      .HOLD_CYCLES (C_HOLD),
      .GAP_CYCLES  (C_GAP),
      .CNT_W       (8),
      .WDOG_CYCLES (C_WDOG),
      .WDOG_W      (16)
   ) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .SW_RST_REQ (SW_RST_REQ),
      .WDOG_KICK  (WDOG_KICK),
      .RST_CORE_N (RST_CORE_N),
      .RST_TX_N   (RST_TX_N),
      .RST_RX_N   (RST_RX_N),
      .DONE       (DONE),
      .STATE      (STATE),
      .WDOG_FLAG  (WDOG_FLAG)
   );

   always #5 CLK = ~CLK;

   // Packed as {WDOG_FLAG, DONE, RST_RX_N, RST_TX_N, RST_CORE_N, STATE}
   function automatic logic [6:0] obs_out();
      return {WDOG_FLAG, DONE, RST_RX_N, RST_TX_N, RST_CORE_N, STATE};
   endfunction

   // Expected outputs e edges after the sequence started (e=0: restart edge)
   function automatic logic [6:0] exp_out(input int e, input bit flag);
      logic       c, t, r;
      logic [1:0] st;
      c  = (e >= C_HOLD);
      t  = (e >= C_HOLD + C_GAP);
      r  = (e >= C_HOLD + 2 * C_GAP);
      st = r ? 2'd3 : (t ? 2'd2 : (c ? 2'd1 : 2'd0));
      return {flag, r, r, t, c, st};
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step_chk(input string tag, input int e);
      @(posedge CLK);
      #1;
      check_val($sformatf("%s e=%0d", tag, e), 32'(obs_out()), 32'(exp_out(e, exp_flag)));
   endtask

   task automatic run_seq(input string tag, input int from, input int to);
      for (int e = from; e <= to; e++) step_chk(tag, e);
   endtask

   task automatic sw_pulse(input string tag);
      SW_RST_REQ = 1'b1;
      step_chk(tag, 0);
      SW_RST_REQ = 1'b0;
   endtask

   task automatic run_unkicked(input string tag, input int n);
      WDOG_KICK = 1'b0;
      for (int i = 0; i < n; i++) step_chk(tag, C_RUN);
   endtask

   initial begin
      #100000;
      $display("FAIL time_limit: got no end of run, want finish before 100000");
      $fatal(1, "time limit");
   end

   initial begin
      // Reset state while RST is held low
      repeat (3) @(posedge CLK);
      #1;
      check_val("reset_state", 32'(obs_out()), 32'(exp_out(0, 1'b0)));

      // Power-up release: 16/20/24
      @(negedge CLK);
      RST = 1'b1;
      run_seq("powerup", 1, C_RUN + 6);

      // Software reset from RUN
      sw_pulse("sw_run");
      run_seq("sw_run", 1, C_RUN);

      // Software reset held 3 edges during GAP1
      sw_pulse("pre_mid");
      run_seq("pre_mid", 1, C_HOLD + 1);
      SW_RST_REQ = 1'b1;
      for (int i = 0; i < 3; i++) step_chk("sw_held", 0);
      SW_RST_REQ = 1'b0;
      run_seq("sw_held_rel", 1, C_RUN);

      // Kicks every 9 edges keep RUN
      for (int k = 0; k < 4; k++) begin
         run_unkicked("wd_kicked", C_WDOG - 2);
         WDOG_KICK = 1'b1;
         step_chk("wd_kick", C_RUN);
         WDOG_KICK = 1'b0;
      end

      // Kick on the expiry edge prevents the timeout
      run_unkicked("wd_pre_exp", C_WDOG - 1);
      WDOG_KICK = 1'b1;
      step_chk("wd_kick_exp", C_RUN);
      WDOG_KICK = 1'b0;

      // Software request on the expiry edge restarts without the flag
      run_unkicked("wd_pre_sw", C_WDOG - 1);
      sw_pulse("wd_sw_exp");
      run_seq("wd_sw_exp", 1, C_RUN);

      // Stop kicking: timeout at the 10th unkicked edge
      run_unkicked("wd_idle", C_WDOG - 1);
`ifdef RST_SEQ_WDOG_EN
      exp_flag = 1'b1;
      step_chk("wd_timeout", 0);
      run_seq("wd_after", 1, C_RUN);
`else
      step_chk("wd_off", C_RUN);
      run_unkicked("wd_off", C_WDOG);
`endif

      // Async RST during GAP2, then full timing again
      sw_pulse("pre_rst");
      run_seq("pre_rst", 1, C_HOLD + C_GAP + 1);
      #2;
      RST = 1'b0;
      #1;
      exp_flag = 1'b0;
      check_val("rst_async", 32'(obs_out()), 32'(exp_out(0, 1'b0)));
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      run_seq("rst_rel", 1, C_RUN + 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
